// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC frame engine.
// The entry record is sized for the widest supported tof/intensity; users keep the low bits.
package tdc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_DRAIN
    } state_t;

    localparam int ENTRY_TOF_W = 32;
    localparam int ENTRY_INT_W = 16;

    typedef struct packed {
        logic [ENTRY_TOF_W-1:0] tof;
        logic [ENTRY_INT_W-1:0] intensity;
    } entry_t;

    localparam logic [7:0] SAT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == SAT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// Thermometer snapshot to fine code: popcount of the taps modulo NPHASE.
// The running sum is FINE_W bits wide, so wrap-around gives the modulo for free (all-ones -> 0).
module tdc_therm_decode #(
    parameter  int NPHASE = 32,
    localparam int FINE_W = $clog2(NPHASE)
) (
    input  logic [NPHASE-1:0] therm,
    output logic [FINE_W-1:0] code
);

    logic [NPHASE:0][FINE_W-1:0] psum;

    assign psum[0] = '0;

    generate
        for (genvar gi = 0; gi < NPHASE; gi++) begin : g_pop
            assign psum[gi+1] = psum[gi] + FINE_W'(therm[gi]);
        end
    endgenerate

    assign code = psum[NPHASE];

endmodule

// File: rtl/tdc_frame_engine.sv
// Frame-based TDC: time-stamps hits against a start event, keeps the DEPTH brightest hits,
// then streams them out. Optional overflow counter enabled by macro TDC_OVF_CNT_EN.
module tdc_frame_engine
    import tdc_pkg::*;
#(
    parameter int CNT_W  = 10,
    parameter int NPHASE = 32,
    parameter int DEPTH  = 3,
    parameter int INT_W  = 5
) (
    input  logic                            clk5,
    input  logic                            rst_n,
    input  logic                            start_pls,
    input  logic [NPHASE-1:0]               start_phase,
    input  logic                            hit_pls,
    input  logic [NPHASE-1:0]               hit_phase,
    input  logic [INT_W-1:0]                hit_int,
    input  logic [CNT_W-1:0]                range,
    output logic [CNT_W+$clog2(NPHASE)-1:0] o_data,
    output logic [INT_W-1:0]                o_int,
    output logic                            o_valid,
    output logic                            o_last,
    input  logic                            o_ready,
    output logic                            frame_int,
    output logic [7:0]                      drop_cnt,
    output logic [7:0]                      ovf_cnt
);

    localparam int FINE_W = $clog2(NPHASE);
    localparam int TOF_W  = CNT_W + FINE_W;
    localparam int NUM_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [NUM_W-1:0] DEPTH_N = NUM_W'(DEPTH);

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    range_reg;
    logic [FINE_W-1:0]   start_code_reg;
    logic [NUM_W-1:0]    num_reg;
    logic [IDX_W-1:0]    rd_reg;
    logic [7:0]          drop_reg;
    logic                frame_int_reg;
    entry_t              entries_reg [DEPTH];

    logic [FINE_W-1:0]   start_code_next;
    logic [FINE_W-1:0]   stop_code_next;
    logic [TOF_W-1:0]    raw_tof;
    logic [TOF_W-1:0]    start_ext;
    logic [TOF_W-1:0]    tof_next;
    entry_t              hit_entry_next;
    logic [IDX_W-1:0]    min_idx_next;
    logic                replace_next;
    logic                table_full;

    tdc_therm_decode #(.NPHASE(NPHASE)) u_start_dec (
        .therm (start_phase),
        .code  (start_code_next)
    );

    tdc_therm_decode #(.NPHASE(NPHASE)) u_hit_dec (
        .therm (hit_phase),
        .code  (stop_code_next)
    );

    // {counter, stop} is counter*NPHASE + stop because NPHASE is a power of two.
    assign raw_tof   = {cnt_reg, stop_code_next};
    assign start_ext = TOF_W'(start_code_reg);
    assign tof_next  = (raw_tof < start_ext) ? '0 : raw_tof - start_ext;

    assign hit_entry_next = '{tof: ENTRY_TOF_W'(tof_next), intensity: ENTRY_INT_W'(hit_int)};
    assign table_full     = (num_reg == DEPTH_N);

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_idx_next = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (entries_reg[i].intensity < entries_reg[min_idx_next].intensity) begin
                min_idx_next = IDX_W'(i);
            end
        end
    end

    assign replace_next = ENTRY_INT_W'(hit_int) > entries_reg[min_idx_next].intensity;

    always_ff @(posedge clk5 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            range_reg      <= '0;
            start_code_reg <= '0;
            num_reg        <= '0;
            rd_reg         <= '0;
            drop_reg       <= '0;
            frame_int_reg  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_reg[i] <= '0;
            end
        end else begin
            frame_int_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start_pls) begin
                        state_reg      <= S_ARMED;
                        cnt_reg        <= '0;
                        range_reg      <= range;
                        start_code_reg <= start_code_next;
                        num_reg        <= '0;
                        rd_reg         <= '0;
                    end
                end
                S_ARMED: begin
                    if (start_pls) begin
                        drop_reg <= sat_inc(drop_reg);
                    end
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == range_reg) begin
                        state_reg     <= S_DRAIN;
                        frame_int_reg <= 1'b1;
                        rd_reg        <= '0;
                    end
                    if (hit_pls) begin
                        if (!table_full) begin
                            entries_reg[num_reg[IDX_W-1:0]] <= hit_entry_next;
                            num_reg <= num_reg + NUM_W'(1);
                        end else if (replace_next) begin
                            entries_reg[min_idx_next] <= hit_entry_next;
                        end
                    end
                end
                S_DRAIN: begin
                    if (start_pls) begin
                        drop_reg <= sat_inc(drop_reg);
                    end
                    if (num_reg == '0) begin
                        state_reg <= S_IDLE;
                    end else if (o_ready) begin
                        if (o_last) begin
                            state_reg <= S_IDLE;
                        end else begin
                            rd_reg <= rd_reg + IDX_W'(1);
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef TDC_OVF_CNT_EN
    logic [7:0] ovf_reg;

    always_ff @(posedge clk5 or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= '0;
        end else if (state_reg == S_ARMED && hit_pls && table_full && !replace_next) begin
            ovf_reg <= sat_inc(ovf_reg);
        end
    end

    assign ovf_cnt = ovf_reg;
`else
    assign ovf_cnt = 8'd0;
`endif

    assign o_valid   = (state_reg == S_DRAIN) && (num_reg != '0);
    assign o_last    = o_valid && (NUM_W'(rd_reg) == (num_reg - NUM_W'(1)));
    assign o_data    = o_valid ? entries_reg[rd_reg].tof[TOF_W-1:0] : '0;
    assign o_int     = o_valid ? entries_reg[rd_reg].intensity[INT_W-1:0] : '0;
    assign frame_int = frame_int_reg;
    assign drop_cnt  = drop_reg;

endmodule
